// File: rtl/paddle_capture_if.sv
// Paddle capture signal bundle: trigger/timing inputs and capture results.
interface paddle_capture_if;
    logic       cycle_tick;
    logic       enable;
    logic       start;
    logic       comp_in;
    logic       discharge;
    logic [7:0] paddle_value;
    logic       value_valid;
    logic       busy;
    logic       overrange;

    // Drives triggers and comparator, observes results (board / testbench side)
    modport master (
        output cycle_tick, enable, start, comp_in,
        input  discharge, paddle_value, value_valid, busy, overrange
    );

    // The capture engine itself
    modport slave (
        input  cycle_tick, enable, start, comp_in,
        output discharge, paddle_value, value_valid, busy, overrange
    );
endinterface

// File: rtl/paddle_capture.sv
// Paddle RC timer: discharges the external RC, times the comparator in CPU
// cycles and inverts T(v) = 11*v + floor(v/4) into an 8-bit paddle value.
module paddle_capture #(
    parameter int unsigned DISCH_CYCLES    = 8,
    parameter int unsigned INTERVAL_CYCLES = 16384
) (
    input logic            clk,
    input logic            reset,
    paddle_capture_if.slave bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DISCH   = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;

    localparam logic [15:0] INT_LAST   = 16'(INTERVAL_CYCLES - 1);
    localparam logic [15:0] DISCH_LAST = 16'(DISCH_CYCLES - 1);
    localparam logic [11:0] E_SAT      = 12'd2880;

    logic        meta_q, comp_s_q;
    logic [1:0]  state_q, state_d;
    logic [15:0] int_cnt_q, int_cnt_d;
    logic [15:0] disch_cnt_q, disch_cnt_d;
    logic [11:0] e_cnt_q, e_cnt_d;
    logic [7:0]  v_q, v_d;
    logic [3:0]  step_q, step_d;
    logic        discharge_q, discharge_d;
    logic [7:0]  value_q, value_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        ovr_q, ovr_d;
    logic        auto_hit;
    logic [11:0] e_next;

    // Two-flop synchronizer for the asynchronous comparator
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q   <= 1'b0;
            comp_s_q <= 1'b0;
        end else begin
            meta_q   <= bus.comp_in;
            comp_s_q <= meta_q;
        end
    end

    // Next-state logic: trigger, discharge timing and incremental T(v) inversion
    always_comb begin
        state_d     = state_q;
        int_cnt_d   = int_cnt_q;
        disch_cnt_d = disch_cnt_q;
        e_cnt_d     = e_cnt_q;
        v_d         = v_q;
        step_d      = step_q;
        discharge_d = discharge_q;
        value_d     = value_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        ovr_d       = ovr_q;
        auto_hit    = 1'b0;
        e_next      = e_cnt_q + 12'd1;

        case (state_q)
            S_IDLE: begin
                discharge_d = 1'b0;
                busy_d      = 1'b0;
                auto_hit    = bus.enable && bus.cycle_tick && (int_cnt_q == INT_LAST);
                if (!bus.enable)
                    int_cnt_d = '0;
                else if (bus.cycle_tick)
                    int_cnt_d = int_cnt_q + 16'd1;
                if (bus.start || auto_hit) begin
                    state_d     = S_DISCH;
                    discharge_d = 1'b1;
                    busy_d      = 1'b1;
                    int_cnt_d   = '0;
                    disch_cnt_d = '0;
                end
            end

            S_DISCH: begin
                if (bus.cycle_tick) begin
                    if (disch_cnt_q == DISCH_LAST) begin
                        state_d     = S_MEASURE;
                        discharge_d = 1'b0;
                        disch_cnt_d = '0;
                        e_cnt_d     = '0;
                        v_d         = '0;
                        step_d      = 4'd11;
                    end else begin
                        disch_cnt_d = disch_cnt_q + 16'd1;
                    end
                end
            end

            S_MEASURE: begin
                // step_q holds the ticks remaining until T(v+1); comparator beats a same-clk tick
                if (!comp_s_q) begin
                    value_d   = v_q;
                    ovr_d     = 1'b0;
                    valid_d   = 1'b1;
                    busy_d    = 1'b0;
                    int_cnt_d = '0;
                    state_d   = S_IDLE;
                end else if (bus.cycle_tick) begin
                    e_cnt_d = e_next;
                    if (e_next == E_SAT) begin
                        value_d   = 8'd255;
                        ovr_d     = 1'b1;
                        valid_d   = 1'b1;
                        busy_d    = 1'b0;
                        int_cnt_d = '0;
                        state_d   = S_IDLE;
                    end else if (step_q == 4'd1) begin
                        v_d    = v_q + 8'd1;
                        step_d = (v_q[1:0] == 2'd2) ? 4'd12 : 4'd11;
                    end else begin
                        step_d = step_q - 4'd1;
                    end
                end
            end

            default: begin
                state_d     = S_IDLE;
                discharge_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            int_cnt_q   <= '0;
            disch_cnt_q <= '0;
            e_cnt_q     <= '0;
            v_q         <= '0;
            step_q      <= '0;
            discharge_q <= 1'b0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            int_cnt_q   <= int_cnt_d;
            disch_cnt_q <= disch_cnt_d;
            e_cnt_q     <= e_cnt_d;
            v_q         <= v_d;
            step_q      <= step_d;
            discharge_q <= discharge_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.discharge    = discharge_q;
    assign bus.paddle_value = value_q;
    assign bus.value_valid  = valid_q;
    assign bus.busy         = busy_q;
    assign bus.overrange    = ovr_q;

endmodule
